dot_product_row_feeder: RTL and testbench

Producer-side companion to the 784-input dot-product engine. Accepts one image frame (784 pixel/weight pairs plus a bias) over a serial valid/ready stream, buffers it, then drives the engine's 28-wide pixel/weight row ports on the engine's fixed row schedule. Holds the engine in run via `dp_enable`, captures the engine's 26-bit result after the fixed latency, and returns it on a valid/ready output. Sits between the frame loader and each neuron's dot-product instance.

---
 rtl/dot_product_row_feeder_if.sv | 38 +++
 rtl/dot_product_row_feeder.sv | 217 +++++++++++++++++++++
 tb/tb_dot_product_row_feeder.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/dot_product_row_feeder_if.sv
// Frame-loader / engine / result-consumer signal bundle for dot_product_row_feeder.
// slave  : the feeder's view (accepts input beats, drives engine rows, offers results).
// master : the surrounding environment's view (loader, engine and consumer side).
interface dot_product_row_feeder_if #(
    parameter int COLS        = 28,
    parameter int PIXEL_SIZE  = 10,
    parameter int WEIGHT_SIZE = 19,
    parameter int OUT_SIZE    = 26
);
    // Serial frame input stream
    logic                          in_valid;
    logic                          in_ready;
    logic [PIXEL_SIZE-1:0]         in_pixel;
    logic [WEIGHT_SIZE-1:0]        in_weight;
    logic [WEIGHT_SIZE-1:0]        in_bias;

    // Engine side: one row of pairs, bias, run enable and result
    logic [COLS*PIXEL_SIZE-1:0]    row_pixels;
    logic [COLS*WEIGHT_SIZE-1:0]   row_weights;
    logic [WEIGHT_SIZE-1:0]        bias_out;
    logic                          dp_enable;
    logic [OUT_SIZE-1:0]           result_in;

    // Result output stream
    logic                          out_valid;
    logic [OUT_SIZE-1:0]           out_value;
    logic                          out_ready;

    modport slave (
        input  in_valid, in_pixel, in_weight, in_bias, result_in, out_ready,
        output in_ready, row_pixels, row_weights, bias_out, dp_enable, out_valid, out_value
    );

    modport master (
        output in_valid, in_pixel, in_weight, in_bias, result_in, out_ready,
        input  in_ready, row_pixels, row_weights, bias_out, dp_enable, out_valid, out_value
    );
endinterface

// File: rtl/dot_product_row_feeder.sv
// Purpose: buffer one 784-pair frame + bias, replay it row by row into the dot-product engine, return its result.
// Latency: dp_enable rises the cycle after the last beat; out_valid follows DP_LATENCY+1 cycles later.
// Backpressure: in_ready only in LOAD; result held in OUT until out_ready, then LOAD next cycle.
//
// Ports:
//   clk          rising-edge clock
//   GlobalReset  synchronous active-high reset; aborts any frame in progress
//   bus.slave    in_* beat stream, row_pixels/row_weights/bias_out/dp_enable/result_in
//                engine connection, out_valid/out_value/out_ready result stream
module dot_product_row_feeder #(
    parameter int ROWS        = 28,
    parameter int COLS        = 28,
    parameter int PIXEL_SIZE  = 10,
    parameter int WEIGHT_SIZE = 19,
    parameter int OUT_SIZE    = 26,
    parameter int HOLD        = 7,
    parameter int DP_LATENCY  = 299
) (
    input  logic                   clk,
    input  logic                   GlobalReset,
    dot_product_row_feeder_if.slave bus
);

    localparam int RW  = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW  = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int HW  = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam int CYW = $clog2(DP_LATENCY + 1);
    localparam int PW  = COLS * PIXEL_SIZE;
    localparam int WW  = COLS * WEIGHT_SIZE;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        RUN  = 2'd1,
        OUT  = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Write side: position of the next beat in the frame
    logic [RW-1:0] wr_row_q;
    logic [CW-1:0] wr_col_q;

    // Row under assembly; beats shift in from the top so column 0 ends up at the LSBs
    logic [PW-1:0] col_pix_q;
    logic [WW-1:0] col_wt_q;
    logic [PW-1:0] pix_shift;
    logic [WW-1:0] wt_shift;

    // Frame buffer: one full row per entry
    logic [PW-1:0] frame_pix [ROWS];
    logic [WW-1:0] frame_wt  [ROWS];

    // Read side / run sequencing
    logic [CYW-1:0] cyc_q;
    logic [HW-1:0]  hold_q;
    logic [RW-1:0]  rd_row_q;
    logic [RW-1:0]  next_row;

    // Registered outputs
    logic [PW-1:0]          row_pix_q;
    logic [WW-1:0]          row_wt_q;
    logic [WEIGHT_SIZE-1:0] bias_q;
    logic [OUT_SIZE-1:0]    out_value_q;

    // Handshake / control
    logic in_ready_w;
    logic dp_en_w;
    logic out_vld_w;
    logic beat;
    logic row_end;
    logic last_beat;
    logic first_beat;
    logic run_done;
    logic [PW-1:0] first_row_pix;
    logic [WW-1:0] first_row_wt;

    // in_ready is forced low during the reset cycle itself, not just after it
    assign in_ready_w = (state_q == LOAD) && !GlobalReset;
    assign beat       = bus.in_valid && in_ready_w;
    assign row_end    = (wr_col_q == CW'(COLS - 1));
    assign last_beat  = beat && row_end && (wr_row_q == RW'(ROWS - 1));
    assign first_beat = beat && (wr_col_q == '0) && (wr_row_q == '0);
    assign run_done   = (state_q == RUN) && (cyc_q == CYW'(DP_LATENCY));

    assign pix_shift = {bus.in_pixel,  col_pix_q[PW-1:PIXEL_SIZE]};
    assign wt_shift  = {bus.in_weight, col_wt_q[WW-1:WEIGHT_SIZE]};

    // Row 0 must be on the row ports in the very first dp_enable cycle, so it is
    // loaded on the edge that accepts the last beat. With a single-row frame that
    // row is still in the shift register at that edge.
    assign first_row_pix = (ROWS == 1) ? pix_shift : frame_pix[0];
    assign first_row_wt  = (ROWS == 1) ? wt_shift  : frame_wt[0];

    // Row to present in the next RUN cycle: advance every HOLD cycles, stick on the last row
    always_comb begin
        next_row = rd_row_q;
        if ((hold_q == HW'(HOLD - 1)) && (rd_row_q != RW'(ROWS - 1))) begin
            next_row = rd_row_q + 1'b1;
        end
    end

    // Next-state and state-decoded outputs
    always_comb begin
        state_d   = state_q;
        dp_en_w   = 1'b0;
        out_vld_w = 1'b0;
        case (state_q)
            LOAD: begin
                if (last_beat) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                dp_en_w = 1'b1;
                if (run_done) begin
                    state_d = OUT;
                end
            end
            OUT: begin
                out_vld_w = 1'b1;
                if (bus.out_ready) begin
                    state_d = LOAD;
                end
            end
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (GlobalReset) begin
            state_q <= LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    // Frame storage carries no reset: a reset discards the frame by rewinding the
    // write position, and stale contents are never presented before being rewritten.
    always_ff @(posedge clk) begin
        if (beat) begin
            col_pix_q <= pix_shift;
            col_wt_q  <= wt_shift;
            if (row_end) begin
                frame_pix[wr_row_q] <= pix_shift;
                frame_wt[wr_row_q]  <= wt_shift;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (GlobalReset) begin
            wr_row_q    <= '0;
            wr_col_q    <= '0;
            cyc_q       <= '0;
            hold_q      <= '0;
            rd_row_q    <= '0;
            row_pix_q   <= '0;
            row_wt_q    <= '0;
            bias_q      <= '0;
            out_value_q <= '0;
        end else begin
            case (state_q)
                LOAD: begin
                    if (beat) begin
                        if (row_end) begin
                            wr_col_q <= '0;
                            wr_row_q <= (wr_row_q == RW'(ROWS - 1)) ? '0 : wr_row_q + 1'b1;
                        end else begin
                            wr_col_q <= wr_col_q + 1'b1;
                        end
                    end
                    if (first_beat) begin
                        bias_q <= bus.in_bias;
                    end
                    if (last_beat) begin
                        cyc_q     <= '0;
                        hold_q    <= '0;
                        rd_row_q  <= '0;
                        row_pix_q <= first_row_pix;
                        row_wt_q  <= first_row_wt;
                    end
                end
                RUN: begin
                    if (run_done) begin
                        out_value_q <= bus.result_in;
                    end else begin
                        cyc_q     <= cyc_q + 1'b1;
                        hold_q    <= (hold_q == HW'(HOLD - 1)) ? '0 : hold_q + 1'b1;
                        rd_row_q  <= next_row;
                        row_pix_q <= frame_pix[next_row];
                        row_wt_q  <= frame_wt[next_row];
                    end
                end
                OUT: begin
                    if (bus.out_ready) begin
                        wr_row_q <= '0;
                        wr_col_q <= '0;
                        cyc_q    <= '0;
                    end
                end
                default: begin
                    wr_row_q <= '0;
                    wr_col_q <= '0;
                end
            endcase
        end
    end

    assign bus.in_ready    = in_ready_w;
    assign bus.dp_enable   = dp_en_w;
    assign bus.out_valid   = out_vld_w;
    assign bus.out_value   = out_value_q;
    assign bus.row_pixels  = row_pix_q;
    assign bus.row_weights = row_wt_q;
    assign bus.bias_out    = bias_q;

endmodule

// File: tb/tb_dot_product_row_feeder.sv
module tb_dot_product_row_feeder;

    localparam int ROWS  = 28;
    localparam int COLS  = 28;
    localparam int PS    = 10;
    localparam int WS    = 19;
    localparam int OS    = 26;
    localparam int HOLD  = 7;
    localparam int LAT   = 299;
    localparam int FRAME = ROWS * COLS;

    logic clk = 1'b0;
    logic GlobalReset;

    always #5 clk = ~clk;

    dot_product_row_feeder_if #(.COLS(COLS), .PIXEL_SIZE(PS), .WEIGHT_SIZE(WS), .OUT_SIZE(OS)) bus ();

    dot_product_row_feeder #(
        .ROWS(ROWS), .COLS(COLS), .PIXEL_SIZE(PS), .WEIGHT_SIZE(WS),
        .OUT_SIZE(OS), .HOLD(HOLD), .DP_LATENCY(LAT)
    ) dut (
        .clk         (clk),
        .GlobalReset (GlobalReset),
        .bus         (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference frame: what was actually handed over, beat by beat
    logic [PS-1:0] f_pix [FRAME];
    logic [WS-1:0] f_wt  [FRAME];
    logic [WS-1:0] f_bias;

    logic [OS-1:0] cur_token;
    logic [OS-1:0] exp_q [$];

    int en_cnt = 0;
    bit prev_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [OS-1:0] garbage();
        logic [OS-1:0] g;
        g = OS'($urandom);
        if (g == cur_token) g = g ^ 26'h1;
        return g;
    endfunction

    // Engine model + monitor, sampled mid-cycle
    always @(negedge clk) begin : monitor
        logic [COLS*PS-1:0] ep;
        logic [COLS*WS-1:0] ew;
        int r;
        if (GlobalReset) begin
            en_cnt        = 0;
            prev_en       = 1'b0;
            bus.result_in = garbage();
        end else begin
            if (bus.dp_enable) begin
                r = en_cnt / HOLD;
                if (r > ROWS - 1) r = ROWS - 1;
                for (int c = 0; c < COLS; c++) begin
                    ep[c*PS +: PS] = f_pix[r*COLS + c];
                    ew[c*WS +: WS] = f_wt[r*COLS + c];
                end
                vectors++;
                if (bus.row_pixels !== ep) begin
                    miscompares++;
                    $display("FAIL row_pixels cyc=%0d: got %h expected %h", en_cnt, bus.row_pixels, ep);
                end
                vectors++;
                if (bus.row_weights !== ew) begin
                    miscompares++;
                    $display("FAIL row_weights cyc=%0d: got %h expected %h", en_cnt, bus.row_weights, ew);
                end
                chk("bias_out_run", 64'(bus.bias_out), 64'(f_bias));
                chk("in_ready_run", 64'(bus.in_ready), 64'd0);
                bus.result_in = (en_cnt == LAT) ? cur_token : garbage();
                en_cnt++;
            end else begin
                if (prev_en) begin
                    chk("dp_enable_run_length", 64'(en_cnt), 64'(LAT + 1));
                    chk("out_valid_after_run", 64'(bus.out_valid), 64'd1);
                end
                en_cnt        = 0;
                bus.result_in = garbage();
            end
            prev_en = bus.dp_enable;
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL out_value: got %0h with no result expected", bus.out_value);
                end else begin
                    chk("out_value", 64'(bus.out_value), 64'(exp_q.pop_front()));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode 0: constant valid, pixel=n%1024 weight=n
    // mode 1: same data, valid on every other cycle
    // mode 2: random data, random gaps, bias changing after beat 0
    task automatic send_frame(input int mode, input logic [WS-1:0] bias,
                              input logic [OS-1:0] token, output int iters);
        int n;
        n     = 0;
        iters = 0;
        cur_token = token;
        while (n < FRAME) begin
            bit v;
            logic [PS-1:0] p;
            logic [WS-1:0] w;
            logic [WS-1:0] b;
            case (mode)
                0:       v = 1'b1;
                1:       v = iters[0];
                default: v = ($urandom_range(0, 3) != 0);
            endcase
            if (mode < 2) begin
                p = PS'(n % 1024);
                w = WS'(n);
                b = bias;
            end else begin
                p = PS'($urandom);
                w = WS'($urandom);
                b = (n == 0) ? bias : WS'($urandom);
            end
            if (!v) begin
                p = PS'($urandom);
                w = WS'($urandom);
            end
            bus.in_valid  = v;
            bus.in_pixel  = p;
            bus.in_weight = w;
            bus.in_bias   = b;
            bus.out_ready = 1'($urandom);
            if (v && bus.in_ready) begin
                f_pix[n] = p;
                f_wt[n]  = w;
                if (n == 0) f_bias = b;
                n++;
            end
            iters++;
            if (iters > 10000) begin
                vectors++;
                miscompares++;
                $display("FAIL load_timeout: got %0d beats expected %0d", n, FRAME);
                break;
            end
            tick();
        end
        exp_q.push_back(token);
        // Keep offering junk beats; the block must not take them outside LOAD
        bus.in_valid  = 1'b1;
        bus.in_pixel  = PS'($urandom);
        bus.in_weight = WS'($urandom);
        bus.in_bias   = WS'($urandom);
        bus.out_ready = 1'b0;
    endtask

    task automatic wait_out(input int hold);
        int t;
        logic [OS-1:0] v;
        t = 0;
        bus.out_ready = 1'b0;
        while (!bus.out_valid && t < 2000) begin
            tick();
            t++;
        end
        chk("out_valid_seen", 64'(bus.out_valid), 64'd1);
        v = bus.out_value;
        repeat (hold) begin
            tick();
            chk("hold_out_valid", 64'(bus.out_valid), 64'd1);
            chk("hold_out_value", 64'(bus.out_value), 64'(v));
            chk("hold_in_ready", 64'(bus.in_ready), 64'd0);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        chk("post_out_valid", 64'(bus.out_valid), 64'd0);
        chk("post_in_ready", 64'(bus.in_ready), 64'd1);
        chk("post_dp_enable", 64'(bus.dp_enable), 64'd0);
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_dp_enable"}, 64'(bus.dp_enable), 64'd0);
        chk({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
        chk({tag, "_out_value"}, 64'(bus.out_value), 64'd0);
        chk({tag, "_row_pixels"}, 64'(|bus.row_pixels), 64'd0);
        chk({tag, "_row_weights"}, 64'(|bus.row_weights), 64'd0);
        chk({tag, "_bias_out"}, 64'(bus.bias_out), 64'd0);
        chk({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int it;
        GlobalReset   = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_pixel  = '0;
        bus.in_weight = '0;
        bus.in_bias   = '0;
        bus.out_ready = 1'b0;
        repeat (3) tick();
        chk("in_ready_during_reset", 64'(bus.in_ready), 64'd0);
        GlobalReset = 1'b0;
        #1;
        check_reset_state("reset");

        // Directed frame: ramp data, constant valid, known result
        send_frame(0, 19'h1234, 26'h2ABCDEF, it);
        chk("load_cycles_const", 64'(it), 64'(FRAME));
        chk("bias_out_frame0", 64'(bus.bias_out), 64'h1234);
        wait_out(0);

        // Same data with alternating valid, consumer stalls 50 cycles
        send_frame(1, 19'h1234, OS'($urandom) | 26'h1, it);
        chk("load_cycles_alt", 64'(it), 64'(2 * FRAME));
        wait_out(50);

        // Reset in the middle of a run
        send_frame(2, WS'($urandom), OS'($urandom) | 26'h1, it);
        chk("run_started", 64'(bus.dp_enable), 64'd1);
        repeat (100) tick();
        GlobalReset = 1'b1;
        #1;
        chk("in_ready_mid_reset", 64'(bus.in_ready), 64'd0);
        tick();
        GlobalReset = 1'b0;
        #1;
        exp_q.delete();
        check_reset_state("midrun_reset");

        // Fresh random frames after the abort
        for (int k = 0; k < 3; k++) begin
            send_frame(2, WS'($urandom), OS'($urandom) | 26'h1, it);
            wait_out($urandom_range(0, 5));
        end

        repeat (5) tick();
        chk("results_drained", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
